vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the character display. Produces a pixel-enable strobe, sync/visible signals and text-cell coordinates for any resolution, porch set, sync polarity, clock divider and glyph size. Feeds the character/attribute memory fetch and the glyph ROM in the display controller, and replaces the fixed 640x480 generator with a single-clock-domain design.

## Interface
- CLK_DIV, 2: clk cycles per pixel (>=1)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal pixels per region
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical lines per region
- HS_POL, 0; VS_POL, 0: sync asserted level (0 = active low)
- CHR_W, 8 (1..8); CHR_H, 16 (1..16): glyph cell size in pixels/lines
- TXTCOL_W, 7; TXTROW_W, 5: text coordinate widths
- BLINK_HALF, 30: frames per blink phase (>=1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixen  out  1  pixel enable, high one clk in every CLK_DIV
- x  out  11  current pixel column, 0..H_total-1
- y  out  11  current line, 0..V_total-1
- visible  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- line_start  out  1  high while x==0
- frame_start  out  1  high while x==0 and y==0
- txtcol  out  TXTCOL_W  x / CHR_W
- chrcol  out  3  x mod CHR_W
- txtrow  out  TXTROW_W  y / CHR_H
- chrrow  out  4  y mod CHR_H
- blink  out  1  blink phase

## Operation
- H_total = H_ACTIVE+H_FP+H_SYNC+H_BP; V_total analogous; both must be <=2048.
- Divider dcnt counts 0..CLK_DIV-1, wrapping; pixen = (dcnt==CLK_DIV-1). CLK_DIV=1: pixen constantly 1.
- Position advances only on an edge where pixen=1: x+1; at x==H_total-1, x->0 and y+1; at y==V_total-1 too, y->0 (frame end).
- hsync asserted (==HS_POL) for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vsync likewise on y with V_* and VS_POL.
- Text counters are incremental (no division): chrcol counts 0..CHR_W-1; on wrap txtcol+1 (modulo 2^TXTCOL_W); both clear when x wraps to 0. chrrow/txtrow identical on y, stepping on x wrap, clearing on frame end. They run through blanking.
- Blink: frame counter fcnt 0..BLINK_HALF-1 steps at frame end; on wrap to 0, blink toggles. Sequence: blink=1 for frames 0..BLINK_HALF-1, 0 for the next BLINK_HALF, repeating.
- Reset (async, immediate): dcnt=0, pixen=0 (1 if CLK_DIV=1), x=y=0, visible=1, hsync=~HS_POL, vsync=~VS_POL, line_start=1, frame_start=1, txtcol=chrcol=txtrow=chrrow=0, fcnt=0, blink=1. Reset mid-frame aborts the frame; generation restarts at (0,0).

## Timing
- All outputs except pixen are registered and mutually consistent: every output corresponds to the current (x,y), no pipeline skew between them.
- Each position, including (0,0) after reset release, lasts exactly CLK_DIV clk cycles; pixen is high in the last of them.
- Cycle 0 = first cycle after reset release. CLK_DIV=2: pixen high in cycles 1,3,5...; (0,0) in cycles 0-1, (1,0) in cycles 2-3.
- Line = H_total*CLK_DIV clk; frame = H_total*V_total*CLK_DIV clk.
- Simultaneous x wrap, y wrap and fcnt wrap occur on the same edge; blink changes on the edge entering (0,0).

## Test plan
- Defaults, release reset -> pixen high in cycles 1,3,5; x=1 first in cycle 2; reset values exactly as listed.
- Defaults, one line -> visible high x 0..639, hsync=0 exactly x 656..751, line_start period 1600 clk.
- Defaults, one frame -> vsync=0 exactly y 490..491, visible low y>=480, frame_start period 840000 clk.
- Defaults at (637,479) -> txtcol=79, chrcol=5, txtrow=29, chrrow=15; CHR_W=6, x=13 -> txtcol=2, chrcol=1; HS_POL=1 -> hsync=1 at x 656..751 only.
- BLINK_HALF=2, 5 frames -> blink 1,1,0,0,1 for frames 0..4, changing at frame_start edge.
- Assert reset at y=200, x=300 -> all outputs at reset values in same cycle (async); after release, (0,0) restarts, blink=1, fcnt=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//    Parametrised raster timing generator for the character display.
//    A clock divider produces a pixel-enable strobe; the raster position
//    (x,y) advances once per pixel period. Sync, visible, line/frame start,
//    text-cell coordinates and the blink phase are all registered together
//    from the next position, so every output describes the same (x,y).
//
// Ports
//    clk          in   system clock
//    reset        in   asynchronous active-high reset
//    pixen        out  pixel enable, high in the last clk of each pixel period
//    x, y         out  current pixel column / line (11 bits)
//    visible      out  x < H_ACTIVE and y < V_ACTIVE
//    hsync, vsync out  sync pulses, asserted level HS_POL / VS_POL
//    line_start   out  x == 0
//    frame_start  out  x == 0 and y == 0
//    txtcol       out  x / CHR_W      chrcol  out  x mod CHR_W
//    txtrow       out  y / CHR_H      chrrow  out  y mod CHR_H
//    blink        out  blink phase, toggles every BLINK_HALF frames
module vga_timing_gen #(
   parameter int CLK_DIV    = 2,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int CHR_W      = 8,
   parameter int CHR_H      = 16,
   parameter int TXTCOL_W   = 7,
   parameter int TXTROW_W   = 5,
   parameter int BLINK_HALF = 30
) (
   input  logic                clk,
   input  logic                reset,
   output logic                pixen,
   output logic [10:0]         x,
   output logic [10:0]         y,
   output logic                visible,
   output logic                hsync,
   output logic                vsync,
   output logic                line_start,
   output logic                frame_start,
   output logic [TXTCOL_W-1:0] txtcol,
   output logic [2:0]          chrcol,
   output logic [TXTROW_W-1:0] txtrow,
   output logic [3:0]          chrrow,
   output logic                blink
);

   localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG = H_ACTIVE + H_FP;
   localparam int HS_END = HS_BEG + H_SYNC;
   localparam int VS_BEG = V_ACTIVE + V_FP;
   localparam int VS_END = VS_BEG + V_SYNC;

   // Counter widths never drop to zero, even for CLK_DIV=1 / BLINK_HALF=1.
   localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [DCW-1:0] DC_LAST = DCW'(CLK_DIV - 1);
   localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_HALF - 1);
   localparam logic [10:0]    H_LAST  = 11'(H_TOT - 1);
   localparam logic [10:0]    V_LAST  = 11'(V_TOT - 1);
   localparam logic [2:0]     CC_LAST = 3'(CHR_W - 1);
   localparam logic [3:0]     CR_LAST = 4'(CHR_H - 1);

   // 12-bit thresholds so a region boundary of 2048 still compares correctly.
   localparam logic [11:0] HA_LIM = 12'(H_ACTIVE);
   localparam logic [11:0] VA_LIM = 12'(V_ACTIVE);
   localparam logic [11:0] HS_LO  = 12'(HS_BEG);
   localparam logic [11:0] HS_HI  = 12'(HS_END);
   localparam logic [11:0] VS_LO  = 12'(VS_BEG);
   localparam logic [11:0] VS_HI  = 12'(VS_END);

   localparam logic HSP = (HS_POL != 0);
   localparam logic VSP = (VS_POL != 0);

   logic [DCW-1:0]      dcnt;
   logic [FCW-1:0]      fcnt;

   logic [10:0]         x_n;
   logic [10:0]         y_n;
   logic [TXTCOL_W-1:0] txtcol_n;
   logic [2:0]          chrcol_n;
   logic [TXTROW_W-1:0] txtrow_n;
   logic [3:0]          chrrow_n;
   logic [FCW-1:0]      fcnt_n;
   logic                blink_n;
   logic                visible_n;
   logic                hsync_n;
   logic                vsync_n;
   logic                line_start_n;
   logic                frame_start_n;

   // With CLK_DIV=1 dcnt is stuck at 0 == DC_LAST, so pixen is constantly 1.
   assign pixen = (dcnt == DC_LAST);

   // Next raster position, text-cell counters and blink state.
   always_comb begin
      x_n      = x;
      y_n      = y;
      txtcol_n = txtcol;
      chrcol_n = chrcol;
      txtrow_n = txtrow;
      chrrow_n = chrrow;
      fcnt_n   = fcnt;
      blink_n  = blink;
      if (pixen) begin
         if (x == H_LAST) begin
            x_n      = 11'd0;
            txtcol_n = '0;
            chrcol_n = 3'd0;
            if (y == V_LAST) begin
               y_n      = 11'd0;
               txtrow_n = '0;
               chrrow_n = 4'd0;
               // Frame end: blink flips on the same edge that enters (0,0).
               if (fcnt == FC_LAST) begin
                  fcnt_n  = '0;
                  blink_n = ~blink;
               end else begin
                  fcnt_n = fcnt + FCW'(1);
               end
            end else begin
               y_n = y + 11'd1;
               if (chrrow == CR_LAST) begin
                  chrrow_n = 4'd0;
                  txtrow_n = txtrow + TXTROW_W'(1);
               end else begin
                  chrrow_n = chrrow + 4'd1;
               end
            end
         end else begin
            x_n = x + 11'd1;
            if (chrcol == CC_LAST) begin
               chrcol_n = 3'd0;
               txtcol_n = txtcol + TXTCOL_W'(1);
            end else begin
               chrcol_n = chrcol + 3'd1;
            end
         end
      end else begin
         x_n = x;
      end
   end

   // Decode the next position so registered flags line up with registered x/y.
   always_comb begin
      visible_n     = ({1'b0, x_n} < HA_LIM) && ({1'b0, y_n} < VA_LIM);
      hsync_n       = (({1'b0, x_n} >= HS_LO) && ({1'b0, x_n} < HS_HI)) ? HSP : ~HSP;
      vsync_n       = (({1'b0, y_n} >= VS_LO) && ({1'b0, y_n} < VS_HI)) ? VSP : ~VSP;
      line_start_n  = (x_n == 11'd0);
      frame_start_n = (x_n == 11'd0) && (y_n == 11'd0);
   end

   // Pixel-period divider.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt <= '0;
      end else if (dcnt == DC_LAST) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + DCW'(1);
      end
   end

   // Raster state and all registered outputs; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x           <= 11'd0;
         y           <= 11'd0;
         txtcol      <= '0;
         chrcol      <= 3'd0;
         txtrow      <= '0;
         chrrow      <= 4'd0;
         fcnt        <= '0;
         blink       <= 1'b1;
         visible     <= 1'b1;
         hsync       <= ~HSP;
         vsync       <= ~VSP;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         x           <= x_n;
         y           <= y_n;
         txtcol      <= txtcol_n;
         chrcol      <= chrcol_n;
         txtrow      <= txtrow_n;
         chrrow      <= chrrow_n;
         fcnt        <= fcnt_n;
         blink       <= blink_n;
         visible     <= visible_n;
         hsync       <= hsync_n;
         vsync       <= vsync_n;
         line_start  <= line_start_n;
         frame_start <= frame_start_n;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen.
//    u_def : default 640x480 timing, CLK_DIV=2
//    u_sml : small raster (30x20), CLK_DIV=3, CHR_W=6, CHR_H=5, HS_POL=1,
//            BLINK_HALF=2 -- whole frames fit in a short run
//    u_one : tiny raster (8x6), CLK_DIV=1, BLINK_HALF=1
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic rst_d = 1'b1;
   logic rst_s = 1'b1;
   logic rst_o = 1'b1;

   // default instance
   logic d_pixen, d_vis, d_hs, d_vs, d_ls, d_fs, d_blink;
   logic [10:0] d_x, d_y;
   logic [6:0] d_tcol;
   logic [2:0] d_ccol;
   logic [4:0] d_trow;
   logic [3:0] d_crow;

   // small instance
   logic s_pixen, s_vis, s_hs, s_vs, s_ls, s_fs, s_blink;
   logic [10:0] s_x, s_y;
   logic [2:0] s_tcol;
   logic [2:0] s_ccol;
   logic [2:0] s_trow;
   logic [3:0] s_crow;

   // CLK_DIV=1 instance
   logic o_pixen, o_vis, o_hs, o_vs, o_ls, o_fs, o_blink;
   logic [10:0] o_x, o_y;
   logic [6:0] o_tcol;
   logic [2:0] o_ccol;
   logic [4:0] o_trow;
   logic [3:0] o_crow;

   vga_timing_gen u_def (
      .clk(clk), .reset(rst_d), .pixen(d_pixen), .x(d_x), .y(d_y), .visible(d_vis),
      .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs),
      .txtcol(d_tcol), .chrcol(d_ccol), .txtrow(d_trow), .chrrow(d_crow), .blink(d_blink)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(5),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .HS_POL(1), .VS_POL(0),
      .CHR_W(6), .CHR_H(5), .TXTCOL_W(3), .TXTROW_W(3), .BLINK_HALF(2)
   ) u_sml (
      .clk(clk), .reset(rst_s), .pixen(s_pixen), .x(s_x), .y(s_y), .visible(s_vis),
      .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs),
      .txtcol(s_tcol), .chrcol(s_ccol), .txtrow(s_trow), .chrrow(s_crow), .blink(s_blink)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .BLINK_HALF(1)
   ) u_one (
      .clk(clk), .reset(rst_o), .pixen(o_pixen), .x(o_x), .y(o_y), .visible(o_vis),
      .hsync(o_hs), .vsync(o_vs), .line_start(o_ls), .frame_start(o_fs),
      .txtcol(o_tcol), .chrcol(o_ccol), .txtrow(o_trow), .chrrow(o_crow), .blink(o_blink)
   );

   // Reset is released 1 time unit after a rising edge; the following
   // negedge is then the sample point of cycle 0.
   task automatic test_reset();
      rst_d = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if (d_pixen !== 1'b0) $display("FAIL rst_pixen got=%0d exp=0", d_pixen); else n_pass++;
      n_total++; if (d_x !== 11'd0) $display("FAIL rst_x got=%0d exp=0", d_x); else n_pass++;
      n_total++; if (d_y !== 11'd0) $display("FAIL rst_y got=%0d exp=0", d_y); else n_pass++;
      n_total++; if (d_vis !== 1'b1) $display("FAIL rst_visible got=%0d exp=1", d_vis); else n_pass++;
      n_total++; if (d_hs !== 1'b1) $display("FAIL rst_hsync got=%0d exp=1", d_hs); else n_pass++;
      n_total++; if (d_vs !== 1'b1) $display("FAIL rst_vsync got=%0d exp=1", d_vs); else n_pass++;
      n_total++; if (d_ls !== 1'b1) $display("FAIL rst_line_start got=%0d exp=1", d_ls); else n_pass++;
      n_total++; if (d_fs !== 1'b1) $display("FAIL rst_frame_start got=%0d exp=1", d_fs); else n_pass++;
      n_total++; if (d_tcol !== 7'd0) $display("FAIL rst_txtcol got=%0d exp=0", d_tcol); else n_pass++;
      n_total++; if (d_ccol !== 3'd0) $display("FAIL rst_chrcol got=%0d exp=0", d_ccol); else n_pass++;
      n_total++; if (d_trow !== 5'd0) $display("FAIL rst_txtrow got=%0d exp=0", d_trow); else n_pass++;
      n_total++; if (d_crow !== 4'd0) $display("FAIL rst_chrrow got=%0d exp=0", d_crow); else n_pass++;
      n_total++; if (d_blink !== 1'b1) $display("FAIL rst_blink got=%0d exp=1", d_blink); else n_pass++;
      @(posedge clk); #1 rst_d = 1'b0;
      // cycles 0..5: pixen 0,1,0,1,0,1 ; x 0,0,1,1,2,2
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_total++; if (d_pixen !== ((c % 2) == 1)) $display("FAIL start_pixen c=%0d got=%0d exp=%0d", c, d_pixen, (c % 2) == 1); else n_pass++;
         n_total++; if (d_x !== 11'(c / 2)) $display("FAIL start_x c=%0d got=%0d exp=%0d", c, d_x, c / 2); else n_pass++;
      end
   endtask

   task automatic test_line();
      int vmax, vmin, hmin, hmax, hcnt, nrise, ls_bad, fs1, y1;
      int rise [4];
      logic prev_ls;
      vmax = -1; vmin = 9999; hmin = 9999; hmax = -1; hcnt = 0; nrise = 0; ls_bad = 0;
      fs1 = -1; y1 = -1; prev_ls = 1'b0;
      rst_d = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rst_d = 1'b0;
      for (int c = 0; c < 3300; c++) begin
         @(negedge clk);
         if (d_y == 11'd0) begin
            if (d_vis && int'(d_x) > vmax) vmax = int'(d_x);
            if (!d_vis && int'(d_x) < vmin) vmin = int'(d_x);
            if (!d_hs) begin
               hcnt++;
               if (int'(d_x) < hmin) hmin = int'(d_x);
               if (int'(d_x) > hmax) hmax = int'(d_x);
            end
         end
         if (d_ls !== (d_x == 11'd0)) ls_bad++;
         if (d_ls && !prev_ls) begin
            if (nrise < 4) rise[nrise] = c;
            nrise++;
         end
         prev_ls = d_ls;
         if (c == 1600) begin
            fs1 = int'(d_fs);
            y1  = int'(d_y);
         end
      end
      n_total++; if (vmax !== 639) $display("FAIL line_vis_last got=%0d exp=639", vmax); else n_pass++;
      n_total++; if (vmin !== 640) $display("FAIL line_vis_first_low got=%0d exp=640", vmin); else n_pass++;
      n_total++; if (hmin !== 656) $display("FAIL line_hsync_first got=%0d exp=656", hmin); else n_pass++;
      n_total++; if (hmax !== 751) $display("FAIL line_hsync_last got=%0d exp=751", hmax); else n_pass++;
      n_total++; if (hcnt !== 192) $display("FAIL line_hsync_clks got=%0d exp=192", hcnt); else n_pass++;
      n_total++; if (nrise !== 3) $display("FAIL line_ls_rises got=%0d exp=3", nrise); else n_pass++;
      if (nrise >= 3) begin
         n_total++; if (rise[1] - rise[0] !== 1600) $display("FAIL line_period1 got=%0d exp=1600", rise[1] - rise[0]); else n_pass++;
         n_total++; if (rise[2] - rise[1] !== 1600) $display("FAIL line_period2 got=%0d exp=1600", rise[2] - rise[1]); else n_pass++;
      end
      n_total++; if (ls_bad !== 0) $display("FAIL line_ls_consistency got=%0d exp=0", ls_bad); else n_pass++;
      n_total++; if (y1 !== 1) $display("FAIL line_y_after_wrap got=%0d exp=1", y1); else n_pass++;
      n_total++; if (fs1 !== 0) $display("FAIL line_fs_line1 got=%0d exp=0", fs1); else n_pass++;
   endtask

   task automatic test_text_default();
      rst_d = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rst_d = 1'b0;
      repeat (1275) @(negedge clk);            // cycle 1274 -> (637,0)
      n_total++; if (d_x !== 11'd637) $display("FAIL txt_x637 got=%0d exp=637", d_x); else n_pass++;
      n_total++; if (d_tcol !== 7'd79) $display("FAIL txt_col637 got=%0d exp=79", d_tcol); else n_pass++;
      n_total++; if (d_ccol !== 3'd5) $display("FAIL chr_col637 got=%0d exp=5", d_ccol); else n_pass++;
      repeat (325) @(negedge clk);             // cycle 1599 -> (799,0)
      n_total++; if (d_tcol !== 7'd99) $display("FAIL txt_col799 got=%0d exp=99", d_tcol); else n_pass++;
      n_total++; if (d_ccol !== 3'd7) $display("FAIL chr_col799 got=%0d exp=7", d_ccol); else n_pass++;
      n_total++; if (d_vis !== 1'b0) $display("FAIL vis_x799 got=%0d exp=0", d_vis); else n_pass++;
      repeat (23675) @(negedge clk);           // cycle 25274 -> (637,15)
      n_total++; if (d_y !== 11'd15) $display("FAIL txt_y15 got=%0d exp=15", d_y); else n_pass++;
      n_total++; if (d_trow !== 5'd0) $display("FAIL txt_row15 got=%0d exp=0", d_trow); else n_pass++;
      n_total++; if (d_crow !== 4'd15) $display("FAIL chr_row15 got=%0d exp=15", d_crow); else n_pass++;
      repeat (326) @(negedge clk);             // cycle 25600 -> (0,16)
      n_total++; if (d_trow !== 5'd1) $display("FAIL txt_row16 got=%0d exp=1", d_trow); else n_pass++;
      n_total++; if (d_crow !== 4'd0) $display("FAIL chr_row16 got=%0d exp=0", d_crow); else n_pass++;
      n_total++; if (d_tcol !== 7'd0) $display("FAIL txt_col_wrap got=%0d exp=0", d_tcol); else n_pass++;
      n_total++; if (d_ccol !== 3'd0) $display("FAIL chr_col_wrap got=%0d exp=0", d_ccol); else n_pass++;
   endtask

   task automatic test_small_basic();
      int hmin, hmax, hcnt;
      hmin = 9999; hmax = -1; hcnt = 0;
      rst_s = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if (s_pixen !== 1'b0) $display("FAIL s_rst_pixen got=%0d exp=0", s_pixen); else n_pass++;
      n_total++; if (s_hs !== 1'b0) $display("FAIL s_rst_hsync got=%0d exp=0", s_hs); else n_pass++;
      n_total++; if (s_vs !== 1'b1) $display("FAIL s_rst_vsync got=%0d exp=1", s_vs); else n_pass++;
      @(posedge clk); #1 rst_s = 1'b0;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         if (s_hs) begin
            hcnt++;
            if (int'(s_x) < hmin) hmin = int'(s_x);
            if (int'(s_x) > hmax) hmax = int'(s_x);
         end
         if (c == 39) begin                      // first cycle of x=13
            n_total++; if (s_x !== 11'd13) $display("FAIL s_x13 got=%0d exp=13", s_x); else n_pass++;
            n_total++; if (s_tcol !== 3'd2) $display("FAIL s_txtcol13 got=%0d exp=2", s_tcol); else n_pass++;
            n_total++; if (s_ccol !== 3'd1) $display("FAIL s_chrcol13 got=%0d exp=1", s_ccol); else n_pass++;
            n_total++; if (s_pixen !== 1'b0) $display("FAIL s_pixen39 got=%0d exp=0", s_pixen); else n_pass++;
         end
         if (c == 41) begin
            n_total++; if (s_pixen !== 1'b1) $display("FAIL s_pixen41 got=%0d exp=1", s_pixen); else n_pass++;
            n_total++; if (s_x !== 11'd13) $display("FAIL s_x41 got=%0d exp=13", s_x); else n_pass++;
         end
         if (c == 42) begin
            n_total++; if (s_x !== 11'd14) $display("FAIL s_x42 got=%0d exp=14", s_x); else n_pass++;
         end
      end
      n_total++; if (hmin !== 22) $display("FAIL s_hsync_first got=%0d exp=22", hmin); else n_pass++;
      n_total++; if (hmax !== 24) $display("FAIL s_hsync_last got=%0d exp=24", hmax); else n_pass++;
      n_total++; if (hcnt !== 9) $display("FAIL s_hsync_clks got=%0d exp=9", hcnt); else n_pass++;
   endtask

   task automatic test_small_frames();
      int vmin, vmax, vis_bad, nrise;
      int rise [8];
      logic bl_at [8];
      logic bl_bef [8];
      logic prev_fs, prev_bl;
      logic exp_bl [5];
      exp_bl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vmin = 9999; vmax = -1; vis_bad = 0; nrise = 0; prev_fs = 1'b0; prev_bl = 1'b1;
      rst_s = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rst_s = 1'b0;
      for (int c = 0; c < 9000; c++) begin
         @(negedge clk);
         if (!s_vs) begin
            if (int'(s_y) < vmin) vmin = int'(s_y);
            if (int'(s_y) > vmax) vmax = int'(s_y);
         end
         if (s_vis && s_y >= 11'd12) vis_bad++;
         if (s_fs && !prev_fs) begin
            if (nrise < 8) begin
               rise[nrise]   = c;
               bl_at[nrise]  = s_blink;
               bl_bef[nrise] = prev_bl;
            end
            nrise++;
         end
         prev_fs = s_fs;
         prev_bl = s_blink;
         if (c == 1797) begin                    // (29,19), last position of frame
            n_total++; if (s_tcol !== 3'd4) $display("FAIL s_txtcol29 got=%0d exp=4", s_tcol); else n_pass++;
            n_total++; if (s_ccol !== 3'd5) $display("FAIL s_chrcol29 got=%0d exp=5", s_ccol); else n_pass++;
            n_total++; if (s_trow !== 3'd3) $display("FAIL s_txtrow19 got=%0d exp=3", s_trow); else n_pass++;
            n_total++; if (s_crow !== 4'd4) $display("FAIL s_chrrow19 got=%0d exp=4", s_crow); else n_pass++;
         end
      end
      n_total++; if (vmin !== 14) $display("FAIL s_vsync_first got=%0d exp=14", vmin); else n_pass++;
      n_total++; if (vmax !== 15) $display("FAIL s_vsync_last got=%0d exp=15", vmax); else n_pass++;
      n_total++; if (vis_bad !== 0) $display("FAIL s_vis_vblank got=%0d exp=0", vis_bad); else n_pass++;
      n_total++; if (nrise !== 5) $display("FAIL s_frame_count got=%0d exp=5", nrise); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k < nrise) begin
            n_total++; if (rise[k] !== k * 1800) $display("FAIL s_frame_start%0d got=%0d exp=%0d", k, rise[k], k * 1800); else n_pass++;
            n_total++; if (bl_at[k] !== exp_bl[k]) $display("FAIL s_blink_frame%0d got=%0d exp=%0d", k, bl_at[k], exp_bl[k]); else n_pass++;
         end
      end
      if (nrise >= 5) begin
         // blink must still hold the old phase in the last cycle of the previous frame
         n_total++; if (bl_bef[2] !== 1'b1) $display("FAIL s_blink_before2 got=%0d exp=1", bl_bef[2]); else n_pass++;
         n_total++; if (bl_bef[4] !== 1'b0) $display("FAIL s_blink_before4 got=%0d exp=0", bl_bef[4]); else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      rst_s = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rst_s = 1'b0;
      repeat (6262) @(negedge clk);            // cycle 6261 -> frame 3, (17,9)
      n_total++; if (s_x !== 11'd17) $display("FAIL ar_x_before got=%0d exp=17", s_x); else n_pass++;
      n_total++; if (s_y !== 11'd9) $display("FAIL ar_y_before got=%0d exp=9", s_y); else n_pass++;
      n_total++; if (s_blink !== 1'b0) $display("FAIL ar_blink_before got=%0d exp=0", s_blink); else n_pass++;
      #1 rst_s = 1'b1;
      #1;                                       // no clock edge in between
      n_total++; if (s_x !== 11'd0) $display("FAIL ar_x got=%0d exp=0", s_x); else n_pass++;
      n_total++; if (s_y !== 11'd0) $display("FAIL ar_y got=%0d exp=0", s_y); else n_pass++;
      n_total++; if (s_pixen !== 1'b0) $display("FAIL ar_pixen got=%0d exp=0", s_pixen); else n_pass++;
      n_total++; if (s_vis !== 1'b1) $display("FAIL ar_visible got=%0d exp=1", s_vis); else n_pass++;
      n_total++; if (s_hs !== 1'b0) $display("FAIL ar_hsync got=%0d exp=0", s_hs); else n_pass++;
      n_total++; if (s_vs !== 1'b1) $display("FAIL ar_vsync got=%0d exp=1", s_vs); else n_pass++;
      n_total++; if (s_ls !== 1'b1) $display("FAIL ar_line_start got=%0d exp=1", s_ls); else n_pass++;
      n_total++; if (s_fs !== 1'b1) $display("FAIL ar_frame_start got=%0d exp=1", s_fs); else n_pass++;
      n_total++; if (s_tcol !== 3'd0) $display("FAIL ar_txtcol got=%0d exp=0", s_tcol); else n_pass++;
      n_total++; if (s_ccol !== 3'd0) $display("FAIL ar_chrcol got=%0d exp=0", s_ccol); else n_pass++;
      n_total++; if (s_trow !== 3'd0) $display("FAIL ar_txtrow got=%0d exp=0", s_trow); else n_pass++;
      n_total++; if (s_crow !== 4'd0) $display("FAIL ar_chrrow got=%0d exp=0", s_crow); else n_pass++;
      n_total++; if (s_blink !== 1'b1) $display("FAIL ar_blink got=%0d exp=1", s_blink); else n_pass++;
      @(posedge clk); #1 rst_s = 1'b0;
      @(negedge clk);                           // cycle 0
      n_total++; if (s_x !== 11'd0 || s_y !== 11'd0) $display("FAIL ar_restart got=(%0d,%0d) exp=(0,0)", s_x, s_y); else n_pass++;
      repeat (1800) @(negedge clk);            // cycle 1800: frame 1, still blink=1 if fcnt cleared
      n_total++; if (s_fs !== 1'b1) $display("FAIL ar_fs1800 got=%0d exp=1", s_fs); else n_pass++;
      n_total++; if (s_blink !== 1'b1) $display("FAIL ar_blink1800 got=%0d exp=1", s_blink); else n_pass++;
      repeat (1800) @(negedge clk);            // cycle 3600: frame 2
      n_total++; if (s_fs !== 1'b1) $display("FAIL ar_fs3600 got=%0d exp=1", s_fs); else n_pass++;
      n_total++; if (s_blink !== 1'b0) $display("FAIL ar_blink3600 got=%0d exp=0", s_blink); else n_pass++;
   endtask

   task automatic test_div1();
      rst_o = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if (o_pixen !== 1'b1) $display("FAIL d1_rst_pixen got=%0d exp=1", o_pixen); else n_pass++;
      @(posedge clk); #1 rst_o = 1'b0;
      @(negedge clk);                           // cycle 0
      n_total++; if (o_x !== 11'd0) $display("FAIL d1_x0 got=%0d exp=0", o_x); else n_pass++;
      @(negedge clk);                           // cycle 1
      n_total++; if (o_x !== 11'd1) $display("FAIL d1_x1 got=%0d exp=1", o_x); else n_pass++;
      n_total++; if (o_pixen !== 1'b1) $display("FAIL d1_pixen got=%0d exp=1", o_pixen); else n_pass++;
      repeat (4) @(negedge clk);                // cycle 5 -> x=5, sync
      n_total++; if (o_hs !== 1'b0) $display("FAIL d1_hsync5 got=%0d exp=0", o_hs); else n_pass++;
      @(negedge clk);                           // cycle 6
      n_total++; if (o_hs !== 1'b1) $display("FAIL d1_hsync6 got=%0d exp=1", o_hs); else n_pass++;
      repeat (2) @(negedge clk);                // cycle 8 -> (0,1)
      n_total++; if (o_x !== 11'd0 || o_y !== 11'd1) $display("FAIL d1_wrap got=(%0d,%0d) exp=(0,1)", o_x, o_y); else n_pass++;
      n_total++; if (o_ls !== 1'b1 || o_fs !== 1'b0) $display("FAIL d1_ls_fs got=%0d%0d exp=10", o_ls, o_fs); else n_pass++;
      repeat (24) @(negedge clk);               // cycle 32 -> (0,4), vsync
      n_total++; if (o_vs !== 1'b0) $display("FAIL d1_vsync4 got=%0d exp=0", o_vs); else n_pass++;
      repeat (8) @(negedge clk);                // cycle 40 -> (0,5)
      n_total++; if (o_vs !== 1'b1) $display("FAIL d1_vsync5 got=%0d exp=1", o_vs); else n_pass++;
      repeat (8) @(negedge clk);                // cycle 48 -> frame 1
      n_total++; if (o_fs !== 1'b1 || o_blink !== 1'b0) $display("FAIL d1_frame1 got=fs%0d bl%0d exp=fs1 bl0", o_fs, o_blink); else n_pass++;
      repeat (48) @(negedge clk);               // cycle 96 -> frame 2
      n_total++; if (o_fs !== 1'b1 || o_blink !== 1'b1) $display("FAIL d1_frame2 got=fs%0d bl%0d exp=fs1 bl1", o_fs, o_blink); else n_pass++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_line();
      test_text_default();
      test_small_basic();
      test_small_frames();
      test_async_reset();
      test_div1();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
